// File: rtl/ctrl_sample_fifo_slave_if.sv
// rtl/ctrl_sample_fifo_slave_if.sv - CPU data-bus bundle for the control-sample FIFO slave
interface ctrl_sample_fifo_slave_if;
  logic        cyc;
  logic        we;
  logic [3:0]  sel;
  logic [29:0] adr;
  logic [31:0] dat;
  logic [31:0] rdt_n;
  logic        ack_n;

  modport master (
    output cyc, we, sel, adr, dat,
    input  rdt_n, ack_n
  );

  modport slave (
    input  cyc, we, sel, adr, dat,
    output rdt_n, ack_n
  );
endinterface

// File: rtl/ctrl_sample_fifo_slave.sv
// rtl/ctrl_sample_fifo_slave.sv - CBADC control-sample FIFO bus slave (optional irq: CTRL_FIFO_IRQ_EN)
module ctrl_sample_fifo_slave #(
  parameter int          N_MAX     = 8,
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0002_0000
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 sample_valid,
  input  logic [N_MAX-1:0]     sample_data,
  ctrl_sample_fifo_slave_if.slave bus
`ifdef CTRL_FIFO_IRQ_EN
  ,
  output logic                 irq
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] IDX_DATA   = 2'd0;
  localparam logic [1:0] IDX_STATUS = 2'd1;
  localparam logic [1:0] IDX_CTRL   = 2'd2;
  localparam logic [1:0] IDX_THRESH = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Captured bus access (only the bits any register can use)
  logic        acc_we_q;
  logic [1:0]  acc_idx_q;
  logic [1:0]  acc_sel_q;
  logic [15:0] acc_dat_q;

  // FIFO storage and bookkeeping
  logic [N_MAX-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             enable_q, enable_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  // Registered bus return path (active low)
  logic             ack_n_q, ack_n_d;
  logic [31:0]      rdt_n_q, rdt_n_d;

`ifdef CTRL_FIFO_IRQ_EN
  logic [15:0]      thresh_q, thresh_d;
  logic             irq_q, irq_d;
  logic [15:0]      count16;
`endif

  logic        hit;
  logic        ack_fire;
  logic        empty, full;
  logic        pop_req, pop, push_req, push, flush, clr_flags, ctrl_wr;
  logic [31:0] rd_data;
  logic        unused_bits;

  assign hit      = bus.cyc && (bus.adr[29:2] == BASE_ADDR[31:4]);
  assign ack_fire = (state_q == ST_ACK);
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));

  assign bus.ack_n = ack_n_q;
  assign bus.rdt_n = rdt_n_q;

  assign unused_bits = ^{bus.dat[31:16], bus.sel[3:2], acc_sel_q, acc_dat_q};

  // Bus FSM state register; reset drops any access in flight
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Bus FSM next state: one ack per cyc assertion
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (hit)      state_d = ST_ACK;
      ST_ACK:                state_d = ST_WAIT;
      ST_WAIT: if (!bus.cyc) state_d = ST_IDLE;
      default:               state_d = ST_IDLE;
    endcase
  end

  // Latch the access when a hit is accepted in IDLE
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_we_q  <= 1'b0;
      acc_idx_q <= 2'd0;
      acc_sel_q <= 2'd0;
      acc_dat_q <= 16'd0;
    end else if (state_q == ST_IDLE && hit) begin
      acc_we_q  <= bus.we;
      acc_idx_q <= bus.adr[1:0];
      acc_sel_q <= bus.sel[1:0];
      acc_dat_q <= bus.dat[15:0];
    end
  end

  // Read mux for the latched register index
  always_comb begin
    rd_data = 32'd0;
    case (acc_idx_q)
      IDX_DATA: begin
        if (!empty) rd_data[N_MAX-1:0] = mem_q[rd_ptr_q];
      end
      IDX_STATUS: begin
        rd_data[CW-1:0] = count_q;
        rd_data[16]     = empty;
        rd_data[17]     = full;
        rd_data[18]     = ovf_q;
        rd_data[19]     = unf_q;
        rd_data[20]     = enable_q;
      end
      IDX_CTRL: begin
        rd_data[0] = enable_q;
      end
      IDX_THRESH: begin
`ifdef CTRL_FIFO_IRQ_EN
        rd_data[15:0] = thresh_q;
`endif
      end
      default: rd_data = 32'd0;
    endcase
  end

  // FIFO, flag and control-register next state
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    enable_d  = enable_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    ack_n_d   = 1'b1;
    rdt_n_d   = 32'hFFFF_FFFF;

    ctrl_wr   = ack_fire && acc_we_q && (acc_idx_q == IDX_CTRL) && acc_sel_q[0];
    flush     = ctrl_wr && acc_dat_q[1];
    clr_flags = ctrl_wr && acc_dat_q[2];
    pop_req   = ack_fire && !acc_we_q && (acc_idx_q == IDX_DATA);
    pop       = pop_req && !empty;
    push_req  = sample_valid && enable_q;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    push      = push_req && (!full || pop);

    if (ack_fire) begin
      ack_n_d = 1'b0;
      rdt_n_d = ~rd_data;
    end

    if (ctrl_wr) enable_d = acc_dat_q[0];

    if (clr_flags) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (pop_req && empty)                 unf_d = 1'b1;
    if (push_req && full && !pop && !flush) ovf_d = 1'b1;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Sample storage; only written on an accepted, non-flushed push
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= sample_data;
  end

  // FIFO pointers, flags and registered bus outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      enable_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      ack_n_q  <= 1'b1;
      rdt_n_q  <= 32'hFFFF_FFFF;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      enable_q <= enable_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      ack_n_q  <= ack_n_d;
      rdt_n_q  <= rdt_n_d;
    end
  end

`ifdef CTRL_FIFO_IRQ_EN
  // Threshold register write (byte lanes) and level interrupt compare
  always_comb begin
    thresh_d = thresh_q;
    count16  = 16'd0;
    count16[CW-1:0] = count_q;
    if (ack_fire && acc_we_q && (acc_idx_q == IDX_THRESH)) begin
      if (acc_sel_q[0]) thresh_d[7:0]  = acc_dat_q[7:0];
      if (acc_sel_q[1]) thresh_d[15:8] = acc_dat_q[15:8];
    end
    irq_d = enable_q && (count16 >= thresh_q);
  end

  // Threshold and irq registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      thresh_q <= 16'(DEPTH / 2);
      irq_q    <= 1'b0;
    end else begin
      thresh_q <= thresh_d;
      irq_q    <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_ctrl_sample_fifo_slave.sv
// tb/tb_ctrl_sample_fifo_slave.sv - scoreboard bench for ctrl_sample_fifo_slave
module tb_ctrl_sample_fifo_slave;
  localparam int          N_MAX  = 8;
  localparam int          DEPTH  = 64;
  localparam logic [29:0] BASE_W = 30'h0000_8000;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       sample_valid = 1'b0;
  logic [7:0] sample_data = 8'd0;
`ifdef CTRL_FIFO_IRQ_EN
  logic       irq;
`endif

  ctrl_sample_fifo_slave_if bus();

  ctrl_sample_fifo_slave #(
    .N_MAX(N_MAX), .DEPTH(DEPTH), .BASE_ADDR(32'h0002_0000)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .sample_valid(sample_valid),
    .sample_data(sample_data),
    .bus(bus)
`ifdef CTRL_FIFO_IRQ_EN
    ,
    .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] st(input int cnt, input bit e, input bit f,
                                     input bit o, input bit u, input bit en);
    logic [31:0] v;
    v = 32'd0;
    v[15:0] = 16'(cnt);
    v[16] = e; v[17] = f; v[18] = o; v[19] = u; v[20] = en;
    return v;
  endfunction

  // Monitor: every read acknowledge is compared against the oldest expectation
  always @(negedge clk) begin
    if (bus.ack_n === 1'b0 && bus.we === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: rdt=%h with no read pending", ~bus.rdt_n);
      end else begin
        check("rdata", ~bus.rdt_n, exp_q.pop_front());
      end
    end
  end

  task automatic access(input logic w, input logic [1:0] idx, input logic [31:0] d,
                        input logic [3:0] s, input logic do_push, input logic [7:0] pv);
    int lat;
    bit got;
    @(posedge clk); #1;
    bus.cyc = 1'b1; bus.we = w; bus.adr = BASE_W | {28'd0, idx}; bus.sel = s; bus.dat = d;
    lat = 0;
    got = 0;
    while (!got && lat < 10) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1 && do_push) begin
        sample_valid = 1'b1;
        sample_data  = pv;
      end else begin
        sample_valid = 1'b0;
      end
      if (bus.ack_n === 1'b0) got = 1;
    end
    check("ack_latency", 32'(lat), 32'd2);
    bus.cyc = 1'b0;
    sample_valid = 1'b0;
    @(posedge clk); #1;
    check("ack_width", {31'd0, bus.ack_n}, 32'd1);
  endtask

  task automatic rd(input logic [1:0] idx, input logic [31:0] exp);
    exp_q.push_back(exp);
    access(1'b0, idx, 32'd0, 4'hf, 1'b0, 8'd0);
  endtask

  task automatic wr(input logic [1:0] idx, input logic [31:0] d, input logic [3:0] s);
    access(1'b1, idx, d, s, 1'b0, 8'd0);
  endtask

  task automatic push_n(input logic [7:0] start, input int n);
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      sample_valid = 1'b1;
      sample_data  = start + 8'(i);
      @(posedge clk); #1;
    end
    sample_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lows;
    bus.cyc = 1'b0; bus.we = 1'b0; bus.sel = 4'h0; bus.adr = 30'd0; bus.dat = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ack_n", {31'd0, bus.ack_n}, 32'd1);
    check("reset_rdt_n", bus.rdt_n, 32'hFFFF_FFFF);
    resetn = 1'b1;

    // Reset state and basic push/pop ordering
    rd(2'd1, 32'h0001_0000);
    wr(2'd2, 32'd1, 4'hf);
    push_n(8'h5A, 1);
    push_n(8'hA5, 1);
    rd(2'd1, st(2, 0, 0, 0, 0, 1));
    rd(2'd0, 32'h0000_005A);
    rd(2'd1, st(1, 0, 0, 0, 0, 1));
    rd(2'd0, 32'h0000_00A5);
    rd(2'd1, st(0, 1, 0, 0, 0, 1));
`ifdef CTRL_FIFO_IRQ_EN
    rd(2'd3, 32'd32);
`else
    rd(2'd3, 32'd0);
`endif

    // Overfill, then drain in order
    push_n(8'd0, DEPTH + 3);
    rd(2'd1, st(64, 0, 1, 1, 0, 1));
    for (int i = 0; i < DEPTH; i++) rd(2'd0, 32'(i));
    rd(2'd1, st(0, 1, 0, 1, 0, 1));

    // Underflow and sticky-flag clear
    rd(2'd0, 32'd0);
    rd(2'd1, st(0, 1, 0, 1, 1, 1));
    wr(2'd2, 32'd5, 4'hf);
    rd(2'd1, st(0, 1, 0, 0, 0, 1));
    rd(2'd2, 32'd1);

    // Push concurrent with pop at count 1
    push_n(8'h11, 1);
    exp_q.push_back(32'h0000_0011);
    access(1'b0, 2'd0, 32'd0, 4'hf, 1'b1, 8'h22);
    rd(2'd1, st(1, 0, 0, 0, 0, 1));
    rd(2'd0, 32'h0000_0022);
    rd(2'd1, st(0, 1, 0, 0, 0, 1));

    // Flush beats a concurrent push
    push_n(8'h30, 3);
    rd(2'd1, st(3, 0, 0, 0, 0, 1));
    access(1'b1, 2'd2, 32'd3, 4'hf, 1'b1, 8'h77);
    rd(2'd1, st(0, 1, 0, 0, 0, 1));

    // Disabled capture and byte-lane gating of CTRL
    wr(2'd2, 32'd0, 4'hf);
    push_n(8'h40, 2);
    rd(2'd1, st(0, 1, 0, 0, 0, 0));
    wr(2'd2, 32'd1, 4'he);
    rd(2'd1, st(0, 1, 0, 0, 0, 0));

    // Out-of-window address never acknowledged
    @(posedge clk); #1;
    bus.cyc = 1'b1; bus.we = 1'b0; bus.sel = 4'hf; bus.adr = BASE_W + 30'd4;
    lows = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.ack_n !== 1'b1) lows++;
    end
    bus.cyc = 1'b0;
    check("miss_no_ack", 32'(lows), 32'd0);

    // Reset in the middle of an access drops it
    @(posedge clk); #1;
    bus.cyc = 1'b1; bus.we = 1'b0; bus.adr = BASE_W + 30'd1;
    @(posedge clk); #1;
    resetn = 1'b0;
    bus.cyc = 1'b0;
    #2;
    resetn = 1'b1;
    lows = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bus.ack_n !== 1'b1) lows++;
    end
    check("reset_drop_ack", 32'(lows), 32'd0);
    check("reset_drop_rdt", bus.rdt_n, 32'hFFFF_FFFF);
    rd(2'd1, st(0, 1, 0, 0, 0, 0));

`ifdef CTRL_FIFO_IRQ_EN
    // Threshold interrupt rise and fall
    wr(2'd2, 32'd1, 4'hf);
    wr(2'd3, 32'd4, 4'hf);
    rd(2'd3, 32'd4);
    push_n(8'h60, 4);
    check("irq_before", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    check("irq_rise", {31'd0, irq}, 32'd1);
    rd(2'd0, 32'h0000_0060);
    check("irq_fall", {31'd0, irq}, 32'd0);
`endif

    repeat (2) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
